// File: rtl/traffic_light_monitor_pkg.sv
// Shared light definitions for Traffic_Light_Controller and traffic_light_monitor.
//   RED/YELLOW/GREEN : one-hot colour encodings on the 3-bit light buses
//   IDX_*            : bit/lane index of each light in packed light vectors
//   is_colour        : true for one of the three legal one-hot encodings
//   legal_step       : true for a legal colour change (G->Y, Y->R, R->G)
package traffic_light_defs;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int IDX_M1     = 0;
    localparam int IDX_M2     = 1;
    localparam int IDX_MT     = 2;
    localparam int IDX_S      = 3;
    localparam int NUM_LIGHTS = 4;

    function automatic logic is_colour(input logic [2:0] c);
        return (c == RED) || (c == YELLOW) || (c == GREEN);
    endfunction

    // Only meaningful for an actual change; a hold is not passed in here.
    function automatic logic legal_step(input logic [2:0] from_c, input logic [2:0] to_c);
        return ((from_c == GREEN)  && (to_c == YELLOW)) ||
               ((from_c == YELLOW) && (to_c == RED))    ||
               ((from_c == RED)    && (to_c == GREEN));
    endfunction

endpackage

// File: rtl/traffic_light_monitor_seq.sv
// light_seq_checker: per-light colour history and checks.
//   clk, rst     : clock, synchronous active-high reset
//   sample_i     : light_i carries a registered sample this cycle
//   check_i      : history checks enabled (cleared for the post-reset baseline)
//   light_i      : registered light value
//   enc_err_o    : pulse, light_i not one-hot
//   seq_err_o    : pulse, illegal colour transition
//   yel_err_o    : pulse, yellow ended into red after fewer than MIN_YELLOW samples
//   changed_o    : pulse, valid colour differs from the previous valid colour
//   active_o     : valid green or yellow this cycle (for conflict checking)
module light_seq_checker
    import traffic_light_defs::*;
#(
    parameter int CNT_W      = 6,
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_i,
    input  logic       check_i,
    input  logic [2:0] light_i,
    output logic       enc_err_o,
    output logic       seq_err_o,
    output logic       yel_err_o,
    output logic       changed_o,
    output logic       active_o
);

    localparam logic [CNT_W-1:0] MIN_Y = CNT_W'(MIN_YELLOW);

    logic [2:0]       prev_q, prev_d;
    logic             prev_vld_q, prev_vld_d;
    logic [CNT_W-1:0] ycnt_q, ycnt_d;
    logic             valid;

    always_comb begin
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        ycnt_d     = ycnt_q;
        enc_err_o  = 1'b0;
        seq_err_o  = 1'b0;
        yel_err_o  = 1'b0;
        changed_o  = 1'b0;
        valid      = is_colour(light_i);
        active_o   = sample_i && valid && (light_i != RED);

        if (sample_i && !valid) begin
            enc_err_o = 1'b1;
        end

        if (sample_i && valid) begin
            prev_d     = light_i;
            prev_vld_d = 1'b1;
            if (light_i == YELLOW) begin
                ycnt_d = (&ycnt_q) ? ycnt_q : ycnt_q + 1'b1;
            end else begin
                ycnt_d = '0;
            end

            // prev_vld_q guards against a light whose baseline sample was not one-hot.
            if (check_i && prev_vld_q && (light_i != prev_q)) begin
                changed_o = 1'b1;
                seq_err_o = !legal_step(prev_q, light_i);
                yel_err_o = (prev_q == YELLOW) && (light_i == RED) && (ycnt_q < MIN_Y);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= RED;
            prev_vld_q <= 1'b0;
            ycnt_q     <= '0;
        end else begin
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            ycnt_q     <= ycnt_d;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker on the controller's four light buses.
//   clk, rst       : clock, synchronous active-high reset
//   light_M1/M2/MT/S : observed lights (red 100, yellow 010, green 001)
//   err_enc        : sticky, a light was not one-hot
//   err_conflict   : sticky, conflicting lights active together
//   err_seq        : sticky, illegal colour transition
//   err_yellow     : sticky, yellow shorter than MIN_YELLOW
//   err_stall      : sticky, no light change for MAX_DWELL samples
//   err_light      : sticky per-light enc/seq/yellow errors, {S, MT, M2, M1}
//   phase_chg      : pulse when any light changes
//   phase_len      : length of the phase that just ended, valid with phase_chg
//   ok             : no sticky error set
module traffic_light_monitor
    import traffic_light_defs::*;
#(
    parameter int CNT_W      = 6,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_DWELL  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       light_M1,
    input  logic [2:0]       light_M2,
    input  logic [2:0]       light_MT,
    input  logic [2:0]       light_S,
    output logic             err_enc,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_yellow,
    output logic             err_stall,
    output logic [3:0]       err_light,
    output logic             phase_chg,
    output logic [CNT_W-1:0] phase_len,
    output logic             ok
);

    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(MAX_DWELL - 1);

    // Stage 1: registered inputs and their valid flag.
    logic [NUM_LIGHTS-1:0][2:0] s1_q;
    logic                       s1_vld_q;
    logic                       base_q, base_d;
    logic                       check;

    logic [NUM_LIGHTS-1:0] enc_e, seq_e, yel_e, chg, act;
    logic                  conflict;

    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] phase_len_q, phase_len_d;
    logic             phase_chg_q, phase_chg_d;
    logic             stall;

    logic             err_enc_q, err_conflict_q, err_seq_q, err_yellow_q, err_stall_q;
    logic [3:0]       err_light_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_q[IDX_M1] <= light_M1;
            s1_q[IDX_M2] <= light_M2;
            s1_q[IDX_MT] <= light_MT;
            s1_q[IDX_S]  <= light_S;
            s1_vld_q     <= 1'b1;
        end
    end

    // History checks run only once the baseline sample has been absorbed.
    assign check = s1_vld_q && base_q;

    for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_light
        light_seq_checker #(
            .CNT_W      (CNT_W),
            .MIN_YELLOW (MIN_YELLOW)
        ) u_chk (
            .clk       (clk),
            .rst       (rst),
            .sample_i  (s1_vld_q),
            .check_i   (check),
            .light_i   (s1_q[i]),
            .enc_err_o (enc_e[i]),
            .seq_err_o (seq_e[i]),
            .yel_err_o (yel_e[i]),
            .changed_o (chg[i]),
            .active_o  (act[i])
        );
    end

    always_comb begin
        base_d      = base_q | s1_vld_q;
        dwell_d     = dwell_q;
        phase_len_d = phase_len_q;
        phase_chg_d = 1'b0;
        stall       = 1'b0;

        conflict = (act[IDX_S]  && (act[IDX_M1] || act[IDX_M2] || act[IDX_MT])) ||
                   (act[IDX_MT] && act[IDX_M2]);

        if (check) begin
            if (|chg) begin
                phase_len_d = sat_inc(dwell_q);
                phase_chg_d = 1'b1;
                dwell_d     = '0;
            end else begin
                dwell_d = sat_inc(dwell_q);
                stall   = (dwell_d >= STALL_AT);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= 1'b0;
            dwell_q        <= '0;
            phase_len_q    <= '0;
            phase_chg_q    <= 1'b0;
            err_enc_q      <= 1'b0;
            err_conflict_q <= 1'b0;
            err_seq_q      <= 1'b0;
            err_yellow_q   <= 1'b0;
            err_stall_q    <= 1'b0;
            err_light_q    <= '0;
        end else begin
            base_q         <= base_d;
            dwell_q        <= dwell_d;
            phase_len_q    <= phase_len_d;
            phase_chg_q    <= phase_chg_d;
            err_enc_q      <= err_enc_q      | (|enc_e);
            err_conflict_q <= err_conflict_q | conflict;
            err_seq_q      <= err_seq_q      | (|seq_e);
            err_yellow_q   <= err_yellow_q   | (|yel_e);
            err_stall_q    <= err_stall_q    | stall;
            err_light_q    <= err_light_q | enc_e | seq_e | yel_e;
        end
    end

    assign err_enc      = err_enc_q;
    assign err_conflict = err_conflict_q;
    assign err_seq      = err_seq_q;
    assign err_yellow   = err_yellow_q;
    assign err_stall    = err_stall_q;
    assign err_light    = err_light_q;
    assign phase_chg    = phase_chg_q;
    assign phase_len    = phase_len_q;
    assign ok           = !(err_enc_q || err_conflict_q || err_seq_q || err_yellow_q || err_stall_q);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; a sample driven before
// edge N is reported after edge N+1.
module tb_traffic_light_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] m1 = R, m2 = R, mt = R, s = R;

    logic       err_enc, err_conflict, err_seq, err_yellow, err_stall;
    logic [3:0] err_light;
    logic       phase_chg;
    logic [5:0] phase_len;
    logic       ok;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .CNT_W      (6),
        .MIN_YELLOW (2),
        .MAX_DWELL  (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .light_M1     (m1),
        .light_M2     (m2),
        .light_MT     (mt),
        .light_S      (s),
        .err_enc      (err_enc),
        .err_conflict (err_conflict),
        .err_seq      (err_seq),
        .err_yellow   (err_yellow),
        .err_stall    (err_stall),
        .err_light    (err_light),
        .phase_chg    (phase_chg),
        .phase_len    (phase_len),
        .ok           (ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Flags vector order: {enc, conflict, seq, yellow, stall}.
    task automatic chk_flags(input string tag, input logic [4:0] e, input logic [3:0] el);
        chk({tag, ".flags"}, 32'({err_enc, err_conflict, err_seq, err_yellow, err_stall}), 32'(e));
        chk({tag, ".err_light"}, 32'(err_light), 32'(el));
        chk({tag, ".ok"}, 32'(ok), 32'(e == 5'b0));
    endtask

    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d);
        m1 = a; m2 = b; mt = c; s = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_flags("reset", 5'b0, 4'b0);
        chk("reset.phase_chg", 32'(phase_chg), 32'd0);
        chk("reset.phase_len", 32'(phase_len), 32'd0);
        rst = 1'b0;

        // Legal cycle: G x5, Y x2, all R x1, then S green
        for (int i = 0; i < 5; i++) cyc(G, G, R, R);
        chk("legal.green_hold", 32'(phase_chg), 32'd0);
        cyc(Y, Y, R, R);
        chk("legal.pre_y", 32'(phase_chg), 32'd0);
        cyc(Y, Y, R, R);
        chk("legal.g_to_y.chg", 32'(phase_chg), 32'd1);
        chk("legal.g_to_y.len", 32'(phase_len), 32'd5);
        cyc(R, R, R, R);
        chk("legal.y_hold", 32'(phase_chg), 32'd0);
        cyc(R, R, R, G);
        chk("legal.y_to_r.chg", 32'(phase_chg), 32'd1);
        chk("legal.y_to_r.len", 32'(phase_len), 32'd2);
        cyc(R, R, R, G);
        chk("legal.r_to_sg.chg", 32'(phase_chg), 32'd1);
        chk("legal.r_to_sg.len", 32'(phase_len), 32'd1);
        cyc(R, R, R, G);
        chk("legal.sg_hold", 32'(phase_chg), 32'd0);
        chk_flags("legal", 5'b0, 4'b0);

        // Conflict: S green with MT yellow (baseline sample, still checked)
        do_reset();
        chk_flags("rst1", 5'b0, 4'b0);
        chk("rst1.phase_len", 32'(phase_len), 32'd0);
        cyc(R, R, Y, G);
        chk("conflict.latency", 32'(err_conflict), 32'd0);
        cyc(R, R, Y, G);
        chk_flags("conflict", 5'b01000, 4'b0);
        cyc(R, R, R, Y);
        cyc(R, R, R, Y);
        cyc(R, R, R, R);
        cyc(R, R, R, R);
        chk_flags("conflict.sticky", 5'b01000, 4'b0);

        // Sequence error: M2 green straight to red
        do_reset();
        cyc(R, G, R, R);
        cyc(R, R, R, R);
        chk("seq.baseline", 32'(err_seq), 32'd0);
        cyc(R, R, R, R);
        chk_flags("seq", 5'b00100, 4'b0010);
        chk("seq.phase_chg", 32'(phase_chg), 32'd1);

        // Short yellow on MT: one yellow sample, then red
        do_reset();
        cyc(R, R, R, R);
        cyc(R, R, G, R);
        cyc(R, R, Y, R);
        cyc(R, R, R, R);
        chk("yellow.pre", 32'(err_yellow), 32'd0);
        cyc(R, R, R, R);
        chk_flags("yellow", 5'b00010, 4'b0100);

        // Encoding error on S, then stall with the same phase held
        do_reset();
        cyc(R, R, R, R);          // sample 1: baseline
        cyc(R, R, R, 3'b110);     // sample 2: bad encoding
        cyc(R, R, R, R);          // sample 3
        chk_flags("enc", 5'b10000, 4'b1000);
        for (int i = 4; i <= 20; i++) cyc(R, R, R, R);
        chk_flags("stall.pre", 5'b10000, 4'b1000);
        cyc(R, R, R, R);          // reports sample 20: phase held 20 samples
        chk_flags("stall", 5'b10001, 4'b1000);

        // Reset mid-phase with errors set; M2 G before reset, R after
        cyc(R, G, R, R);
        do_reset();
        chk_flags("rst2", 5'b0, 4'b0);
        chk("rst2.phase_chg", 32'(phase_chg), 32'd0);
        chk("rst2.phase_len", 32'(phase_len), 32'd0);
        cyc(R, R, R, R);
        cyc(R, R, R, R);
        cyc(R, R, R, R);
        chk_flags("post_rst", 5'b0, 4'b0);
        chk("post_rst.phase_chg", 32'(phase_chg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
